sort_result_checker: RTL
========================

Name: sort_result_checker

Overview:
Post-sort verification stage that runs after sort_circuit asserts done. It reads arr_size words back from memory over the read-address and read-data channels and checks that they are in non-decreasing order. It reports pass/fail, the index of the first violation, and a modular sum checksum. A test bench can compare that checksum against the pre-sort sum to catch lost or duplicated elements.

Parameters:
ADDR_WDTH, 4, memory word-address width; depth = 2**ADDR_WDTH
DATA_WDTH, 32, data word width
RESP_WDTH, 1, response width; value 0 = OK, any nonzero = error
SIGNED_CMP, 0, 0 = unsigned order compare, 1 = two's-complement compare

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
arr_size  input  ADDR_WDTH+1  number of words to check, starting at address 0
start  input  1  level request; begins a check when sampled high in IDLE
done  output  1  high while in DONE
pass  output  1  valid when done; 1 = sorted, no errors
err  output  1  valid when done; read error response or illegal arr_size
viol_index  output  ADDR_WDTH  index i of first word with mem[i] < mem[i-1]; 0 if none
checksum  output  DATA_WDTH  sum of all words read, mod 2**DATA_WDTH
ar_valid  output  1  read address valid
ar_ready  input  1  read address accepted
ar_address  output  ADDR_WDTH  read word address
r_valid  input  1  read data valid
r_ready  output  1  checker ready for read data
r_data  input  DATA_WDTH  read data
r_resp  input  RESP_WDTH  read response

Behaviour:
- Reset (async, rst_n=0): state IDLE; done, pass, err, ar_valid, r_ready = 0; ar_address, viol_index, checksum, index counter, prev register = 0. Reset mid-transaction aborts immediately with no further handshakes.
- States: IDLE, ADDR, DATA, DONE, WAIT_LOW.
- IDLE, start=1: latch arr_size into size_q; clear checksum, viol_index, pass, err, index=0, first_flag=1.
  - size_q == 0 -> DONE, pass=1.
  - size_q > 2**ADDR_WDTH -> DONE, err=1, pass=0; no read issued.
  - Otherwise -> ADDR.
- ADDR: ar_valid=1, ar_address=index; both held stable until the cycle ar_valid && ar_ready. On that edge -> DATA with ar_valid=0. Only one read is outstanding at any time.
- DATA: r_ready=1. On r_valid && r_ready:
  - r_resp != 0 -> DONE, err=1, pass=0; the word is not added to checksum.
  - Otherwise: checksum += r_data, width-truncated.
  - If !first_flag, no violation recorded yet, and r_data < prev (signedness per SIGNED_CMP): set viol flag and viol_index = index.
  - prev = r_data; first_flag = 0; index += 1.
  - If index+1 == size_q -> DONE; else -> ADDR.
- Reading continues after a violation so checksum always covers all size_q words.
- DONE: done=1; pass = !err && !viol. Outputs held. start=0 -> IDLE, done=0; results stay held until the next start. A start held high keeps the block in DONE; there is no auto-restart.
- Latency: IDLE start edge -> ADDR next cycle. With zero-wait memory each word costs 2 cycles. N words -> done asserted 2N+1 cycles after the start edge.
- r_valid arriving in ADDR state is ignored (r_ready=0). ar_ready in DATA state is ignored.
- Equal adjacent values are not violations. Only the first violation index is reported.

Test Plan:
- Memory preloaded 1,2,2,5,9, arr_size=5, ar_ready/r_valid always 1 -> done at cycle 11 after start, pass=1, err=0, viol_index=0, checksum=19, exactly 5 AR handshakes at addresses 0..4.
- Memory 3,7,4,8,1, arr_size=5 -> pass=0, err=0, viol_index=2, checksum=23, all 5 words read.
- Memory always_error (r_resp=1), arr_size=4 -> one AR handshake, done, err=1, pass=0, checksum=0.
- arr_size=0 -> done next cycle, pass=1, no ar_valid. arr_size=17 -> done, err=1, no ar_valid.
- SIGNED_CMP=1, words 0xFFFFFFFF, 0x00000001 -> pass=1. Same words with SIGNED_CMP=0 -> viol_index=1.
- Random ar_ready/r_valid stalls, 16 words -> ar_address stable while stalled, same results as no-stall run. rst_n pulsed low mid-DATA -> all outputs 0 immediately. start held high -> stays in DONE, no second pass.

Source files
------------

// File: rtl/sort_result_checker.sv
// rtl/sort_result_checker.sv - post-sort order checker reading memory back over an AR/R channel pair
module sort_result_checker #(
    parameter int ADDR_WDTH  = 4,
    parameter int DATA_WDTH  = 32,
    parameter int RESP_WDTH  = 1,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_WDTH:0]   arr_size,
    input  logic                 start,
    output logic                 done,
    output logic                 pass,
    output logic                 err,
    output logic [ADDR_WDTH-1:0] viol_index,
    output logic [DATA_WDTH-1:0] checksum,
    output logic                 ar_valid,
    input  logic                 ar_ready,
    output logic [ADDR_WDTH-1:0] ar_address,
    input  logic                 r_valid,
    output logic                 r_ready,
    input  logic [DATA_WDTH-1:0] r_data,
    input  logic [RESP_WDTH-1:0] r_resp
);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, WAIT_LOW} state_t;

    localparam logic [ADDR_WDTH:0] DEPTH = (ADDR_WDTH+1)'(1) << ADDR_WDTH;

    state_t               state;
    logic [ADDR_WDTH:0]   size_q;
    logic [ADDR_WDTH:0]   index;
    logic [ADDR_WDTH:0]   index_nxt;
    logic [DATA_WDTH-1:0] prev;
    logic                 first_flag;
    logic                 viol;
    logic                 data_lt;
    logic                 new_viol;

    always_comb begin
        data_lt = 1'b0;
        if (SIGNED_CMP)
            data_lt = $signed(r_data) < $signed(prev);
        else
            data_lt = r_data < prev;
        new_viol  = !first_flag && !viol && data_lt;
        index_nxt = index + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            pass       <= 1'b0;
            err        <= 1'b0;
            viol_index <= '0;
            checksum   <= '0;
            ar_valid   <= 1'b0;
            ar_address <= '0;
            r_ready    <= 1'b0;
            size_q     <= '0;
            index      <= '0;
            prev       <= '0;
            first_flag <= 1'b1;
            viol       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        size_q     <= arr_size;
                        checksum   <= '0;
                        viol_index <= '0;
                        pass       <= 1'b0;
                        err        <= 1'b0;
                        index      <= '0;
                        first_flag <= 1'b1;
                        viol       <= 1'b0;
                        if (arr_size == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else if (arr_size > DEPTH) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state      <= ADDR;
                            ar_valid   <= 1'b1;
                            ar_address <= '0;
                        end
                    end
                end
                ADDR: begin
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (r_valid) begin
                        r_ready <= 1'b0;
                        if (r_resp != '0) begin
                            err   <= 1'b1;
                            pass  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            checksum   <= checksum + r_data;
                            if (new_viol) begin
                                viol       <= 1'b1;
                                viol_index <= index[ADDR_WDTH-1:0];
                            end
                            prev       <= r_data;
                            first_flag <= 1'b0;
                            index      <= index_nxt;
                            // Keep reading past a violation so checksum spans every word.
                            if (index_nxt == size_q) begin
                                done  <= 1'b1;
                                pass  <= !(viol || new_viol);
                                state <= DONE;
                            end else begin
                                ar_valid   <= 1'b1;
                                ar_address <= index_nxt[ADDR_WDTH-1:0];
                                state      <= ADDR;
                            end
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
